// File: rtl/twotoone_stream_arbiter_if.sv
// Signal bundle for the two-source stream arbiter: sources A and B, merged output Z, and select S.
// The arbiter connects through the slave modport; the environment drives the bundle through master.
interface twotoone_stream_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A_DATA;
    logic             A_LAST;
    logic             A_VALID;
    logic             A_READY;

    logic [WIDTH-1:0] B_DATA;
    logic             B_LAST;
    logic             B_VALID;
    logic             B_READY;

    logic [WIDTH-1:0] Z_DATA;
    logic             Z_LAST;
    logic             Z_VALID;
    logic             Z_READY;

    logic             S;

    modport slave (
        input  A_DATA, A_LAST, A_VALID,
        output A_READY,
        input  B_DATA, B_LAST, B_VALID,
        output B_READY,
        output Z_DATA, Z_LAST, Z_VALID,
        input  Z_READY,
        output S
    );

    modport master (
        output A_DATA, A_LAST, A_VALID,
        input  A_READY,
        output B_DATA, B_LAST, B_VALID,
        input  B_READY,
        input  Z_DATA, Z_LAST, Z_VALID,
        output Z_READY,
        input  S
    );
endinterface

// File: rtl/twotoone_stream_arbiter.sv
// Round-robin 2:1 packet arbiter: holds the grant for a whole packet and registers one output beat,
// reporting on S which source the held beat came from.
module twotoone_stream_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    twotoone_stream_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } state_t;

    state_t           state_q, state_d;
    logic             pri_q, pri_d;
    logic [WIDTH-1:0] z_data_q, z_data_d;
    logic             z_last_q, z_last_d;
    logic             z_valid_q, z_valid_d;
    logic             s_q, s_d;

    logic slot_free;
    logic grant_a, grant_b;
    logic a_ready, b_ready;
    logic a_fire, b_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pri_q     <= 1'b0;
            z_data_q  <= '0;
            z_last_q  <= 1'b0;
            z_valid_q <= 1'b0;
            s_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            z_data_q  <= z_data_d;
            z_last_q  <= z_last_d;
            z_valid_q <= z_valid_d;
            s_q       <= s_d;
        end
    end

    // pri_q = 1 means B wins the next tie; a lock overrides the tie logic entirely
    always_comb begin
        slot_free = !z_valid_q || bus.Z_READY;
        grant_a   = bus.A_VALID && (!bus.B_VALID || !pri_q);
        grant_b   = bus.B_VALID && (!bus.A_VALID ||  pri_q);
        a_ready   = slot_free && (((state_q == IDLE) && grant_a) || (state_q == LOCK_A));
        b_ready   = slot_free && (((state_q == IDLE) && grant_b) || (state_q == LOCK_B));
        a_fire    = a_ready && bus.A_VALID;
        b_fire    = b_ready && bus.B_VALID;

        state_d   = state_q;
        pri_d     = pri_q;
        z_data_d  = z_data_q;
        z_last_d  = z_last_q;
        z_valid_d = z_valid_q;
        s_d       = s_q;

        if (a_fire) begin
            z_data_d  = bus.A_DATA;
            z_last_d  = bus.A_LAST;
            z_valid_d = 1'b1;
            s_d       = 1'b0;
            if (bus.A_LAST) begin
                state_d = IDLE;
                pri_d   = 1'b1;
            end else begin
                state_d = LOCK_A;
            end
        end else if (b_fire) begin
            z_data_d  = bus.B_DATA;
            z_last_d  = bus.B_LAST;
            z_valid_d = 1'b1;
            s_d       = 1'b1;
            if (bus.B_LAST) begin
                state_d = IDLE;
                pri_d   = 1'b0;
            end else begin
                state_d = LOCK_B;
            end
        end else if (bus.Z_READY) begin
            z_valid_d = 1'b0;
        end
    end

    assign bus.A_READY = a_ready;
    assign bus.B_READY = b_ready;
    assign bus.Z_DATA  = z_data_q;
    assign bus.Z_LAST  = z_last_q;
    assign bus.Z_VALID = z_valid_q;
    assign bus.S       = s_q;
endmodule

// File: tb/tb_twotoone_stream_arbiter.sv
// Self-checking bench: directed scenarios plus random packet traffic against a behavioural
// model of packet ownership, tie rotation and the single output slot.
module tb_twotoone_stream_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    twotoone_stream_arbiter_if #(.WIDTH(8))  bus();
    twotoone_stream_arbiter_if #(.WIDTH(16)) bus16();

    twotoone_stream_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    twotoone_stream_arbiter #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    int check_count = 0;
    int pass_count  = 0;

    // stimulus per source (index 0 = A, 1 = B)
    bit         src_valid [2];
    logic [7:0] src_data  [2];
    bit         src_last  [2];
    bit         z_ready;

    // model: which source owns an open packet (-1 none), who wins the next tie, output slot
    int         owner;
    int         tie;
    bit         m_full;
    logic [7:0] m_data;
    bit         m_last;
    bit         m_src;
    bit         exp_ready [2];
    bit         accepted  [2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            pass_count++;
    endtask

    task automatic applyStimulus();
        bus.A_VALID = src_valid[0];
        bus.A_DATA  = src_data[0];
        bus.A_LAST  = src_last[0];
        bus.B_VALID = src_valid[1];
        bus.B_DATA  = src_data[1];
        bus.B_LAST  = src_last[1];
        bus.Z_READY = z_ready;
    endtask

    task automatic model_reset();
        owner  = -1;
        tie    = 0;
        m_full = 1'b0;
        m_data = 8'h00;
        m_last = 1'b0;
        m_src  = 1'b0;
        accepted[0] = 1'b0;
        accepted[1] = 1'b0;
    endtask

    task automatic model_grant();
        int winner;
        winner       = -1;
        exp_ready[0] = 1'b0;
        exp_ready[1] = 1'b0;
        if (m_full && !z_ready) return;
        if (owner >= 0) begin
            exp_ready[owner] = 1'b1;
            return;
        end
        if (src_valid[0] && src_valid[1]) winner = tie;
        else if (src_valid[0])            winner = 0;
        else if (src_valid[1])            winner = 1;
        if (winner >= 0) exp_ready[winner] = 1'b1;
    endtask

    task automatic model_edge();
        bit moved;
        moved = 1'b0;
        for (int s = 0; s < 2; s++) begin
            accepted[s] = exp_ready[s] && src_valid[s];
            if (accepted[s]) begin
                moved  = 1'b1;
                m_full = 1'b1;
                m_data = src_data[s];
                m_last = src_last[s];
                m_src  = (s == 1);
                if (src_last[s]) begin
                    owner = -1;
                    tie   = 1 - s;
                end else begin
                    owner = s;
                end
            end
        end
        if (!moved && z_ready) m_full = 1'b0;
    endtask

    // one clock: check the combinational readies, clock it, check the registered output
    task automatic step();
        applyStimulus();
        #1;
        model_grant();
        checkOutput("a_ready", bus.A_READY, exp_ready[0]);
        checkOutput("b_ready", bus.B_READY, exp_ready[1]);
        @(posedge clk);
        model_edge();
        #1;
        checkOutput("z_valid", bus.Z_VALID, m_full);
        if (m_full) begin
            checkOutput("z_data", bus.Z_DATA, m_data);
            checkOutput("z_last", bus.Z_LAST, m_last);
            checkOutput("s",      bus.S,      m_src);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            src_valid[s] = 1'b0;
            src_data[s]  = 8'h00;
            src_last[s]  = 1'b0;
        end
        z_ready = 1'b0;
        applyStimulus();
        model_reset();
        #2;
        checkOutput("rst_z_valid", bus.Z_VALID, 1'b0);
        checkOutput("rst_z_data",  bus.Z_DATA,  8'h00);
        checkOutput("rst_z_last",  bus.Z_LAST,  1'b0);
        checkOutput("rst_s",       bus.S,       1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setSrc(input int s, input bit v, input logic [7:0] d, input bit l);
        src_valid[s] = v;
        src_data[s]  = d;
        src_last[s]  = l;
    endtask

    logic [7:0] seq_data [4];
    bit         seq_s    [4];

    initial begin
        bus16.A_VALID = 1'b0;
        bus16.A_DATA  = '0;
        bus16.A_LAST  = 1'b0;
        bus16.B_VALID = 1'b0;
        bus16.B_DATA  = '0;
        bus16.B_LAST  = 1'b0;
        bus16.Z_READY = 1'b0;

        doReset();

        // wide instance: full-scale and zero data pass through unmodified
        bus16.A_VALID = 1'b1;
        bus16.A_DATA  = 16'hFFFF;
        bus16.A_LAST  = 1'b1;
        bus16.B_VALID = 1'b1;
        bus16.B_DATA  = 16'h0000;
        bus16.B_LAST  = 1'b1;
        bus16.Z_READY = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("w16_data_a", bus16.Z_DATA, 16'hFFFF);
        checkOutput("w16_s_a",    bus16.S,      1'b0);
        @(posedge clk);
        #1;
        checkOutput("w16_data_b", bus16.Z_DATA, 16'h0000);
        checkOutput("w16_s_b",    bus16.S,      1'b1);
        checkOutput("w16_valid",  bus16.Z_VALID, 1'b1);
        bus16.A_VALID = 1'b0;
        bus16.B_VALID = 1'b0;

        // single beat from A
        setSrc(0, 1'b1, 8'h11, 1'b1);
        z_ready = 1'b1;
        step();
        checkOutput("t1_data", bus.Z_DATA, 8'h11);
        checkOutput("t1_s",    bus.S,      1'b0);
        setSrc(0, 1'b0, 8'h00, 1'b0);
        step();

        // both sources streaming single beats alternate strictly
        doReset();
        setSrc(0, 1'b1, 8'h0A, 1'b1);
        setSrc(1, 1'b1, 8'h0B, 1'b1);
        z_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("rr_s",    bus.S,      (i % 2));
            checkOutput("rr_data", bus.Z_DATA, (i % 2 == 0) ? 8'h0A : 8'h0B);
        end

        // A packet locks out B until its last beat
        doReset();
        z_ready = 1'b1;
        seq_data = '{8'h01, 8'h02, 8'h03, 8'hB0};
        seq_s    = '{1'b0, 1'b0, 1'b0, 1'b1};
        setSrc(0, 1'b1, 8'h01, 1'b0);
        step();
        checkOutput("lock_d0", bus.Z_DATA, seq_data[0]);
        setSrc(0, 1'b1, 8'h02, 1'b0);
        setSrc(1, 1'b1, 8'hB0, 1'b1);
        step();
        checkOutput("lock_b_ready", bus.B_READY, 1'b0);
        checkOutput("lock_d1", bus.Z_DATA, seq_data[1]);
        setSrc(0, 1'b1, 8'h03, 1'b1);
        step();
        checkOutput("lock_d2", bus.Z_DATA, seq_data[2]);
        checkOutput("lock_s2", bus.S,      seq_s[2]);
        setSrc(0, 1'b0, 8'h00, 1'b0);
        step();
        checkOutput("lock_d3", bus.Z_DATA, seq_data[3]);
        checkOutput("lock_s3", bus.S,      seq_s[3]);
        setSrc(1, 1'b0, 8'h00, 1'b0);
        step();

        // backpressure: output frozen, no source accepted
        doReset();
        setSrc(0, 1'b1, 8'h0A, 1'b1);
        setSrc(1, 1'b1, 8'h0B, 1'b1);
        z_ready = 1'b1;
        step();
        z_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("hold_data",  bus.Z_DATA,  8'h0A);
            checkOutput("hold_s",     bus.S,       1'b0);
            checkOutput("hold_valid", bus.Z_VALID, 1'b1);
        end
        z_ready = 1'b1;
        step();
        checkOutput("hold_next_s",    bus.S,      1'b1);
        checkOutput("hold_next_data", bus.Z_DATA, 8'h0B);

        // reset in the middle of a B packet
        doReset();
        z_ready = 1'b1;
        setSrc(1, 1'b1, 8'hC1, 1'b0);
        step();
        setSrc(1, 1'b1, 8'hC2, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", bus.Z_VALID, 1'b0);
        model_reset();
        setSrc(0, 1'b1, 8'hA5, 1'b1);
        setSrc(1, 1'b1, 8'hC3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_s",    bus.S,      1'b0);
        checkOutput("post_rst_data", bus.Z_DATA, 8'hA5);

        // random traffic; a presented beat is held until accepted
        doReset();
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < 2; s++) begin
                if (!src_valid[s] || accepted[s]) begin
                    src_valid[s] = ($urandom_range(0, 2) != 0);
                    src_data[s]  = 8'($urandom);
                    src_last[s]  = ($urandom_range(0, 2) == 0);
                end
            end
            z_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
